uc: RTL and testbench
=====================

# uc

Control unit for the `microc` single-cycle datapath. It takes the 6-bit `opcode` and the registered zero flag `z` from the datapath and drives `s_ret`, `s_rre`, `s_inc`, `s_inm`, `we3`, `wez` and `op`. A small sequential supervisor sits around the decode. It tracks subroutine call depth, detects illegal opcodes and stack misuse, and latches a sticky fault that forces the core to execute NOPs.

## Interface
- `STACK_DEPTH`, default 8: capacity of the datapath return-address stack.
- `DEPTH_W`: derived localparam, `$clog2(STACK_DEPTH+1)`.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `opcode` input, 6 bits: current instruction opcode from the datapath.
- `z` input, 1 bit: datapath zero flag, already registered.
- `s_inc` output, 1 bit: 1 selects PC+1; 0 selects a jump target.
- `s_inm` output, 1 bit: 1 selects the immediate as the register-file write data or jump target; 0 selects the ALU result.
- `s_ret` output, 1 bit: 1 selects the popped return address as next PC.
- `s_rre` output, 1 bit: push PC+1 onto the return stack.
- `we3` output, 1 bit: register-file write enable.
- `wez` output, 1 bit: zero-flag write enable.
- `op` output, 3 bits: ALU operation.
- `fault` output, 1 bit: sticky fault flag.
- `fault_code` output, 2 bits: 00 none, 01 illegal opcode, 10 stack underflow, 11 stack overflow.
- `depth` output, `DEPTH_W` bits: current call depth.

## Operation
- Opcode map and decode. Any output not listed for an instruction is 0.
  - `0ooo_xx` (ALU): `we3`=1, `wez`=1, `s_inc`=1, `s_inm`=0, `op`=`opcode[4:2]`. Example: ADD uses `op`=010, SUB uses `op`=011.
  - `100000` (LI): `we3`=1, `s_inc`=1, `s_inm`=1, `op`=000.
  - `110000` (J): `s_inc`=0, `s_inm`=1.
  - `110001` (JZ): taken when `z`=1, otherwise `s_inc`=1.
  - `110010` (JNZ): taken when `z`=0, otherwise `s_inc`=1.
  - `110011` (JAL): `s_inc`=0, `s_inm`=1, `s_rre`=1; `depth` increments by 1.
  - `110100` (RET): `s_inc`=0, `s_ret`=1; `depth` decrements by 1.
  - Every other encoding is illegal.
- States:
  - RUN: normal decode.
  - FAULT: entered from RUN on the first illegal opcode, on RET with `depth`=0, or on JAL with `depth`=`STACK_DEPTH`.
  - FAULT is left only by `reset`.
  - In FAULT, every opcode decodes as NOP: `s_inc`=1, all other outputs 0, `op`=000. `depth` is frozen.
- The faulting instruction is suppressed in its own cycle: NOP outputs, `depth` unchanged.
- `fault_code` records the first fault only. Later faults do not overwrite it.
- Boundary cases:
  - JAL at `depth`=`STACK_DEPTH`-1 is legal and leaves `depth`=`STACK_DEPTH`.
  - RET at `depth`=1 is legal and leaves `depth`=0.
  - There is no wrap-around in `depth`.

## Timing
- Control outputs are combinational (Mealy) from `opcode`, `z` and the state. They are valid in the same cycle, with zero latency.
- `state`, `depth`, `fault` and `fault_code` update at the rising edge following the instruction.
- The `z` written by an ALU op at edge N is the value used by a JZ/JNZ in cycle N+1. No stall is needed.
- While `reset`=1, all control outputs are 0.
- At a rising edge with `reset`=1: state becomes RUN, `depth`=0, `fault`=0, `fault_code`=00.
- Reset asserted mid-operation, including in FAULT, takes effect at the next edge and overrides every other update.

## Configuration
- `UC_STACK_CHECK_EN` defined:
  - `depth` counter is present.
  - Underflow and overflow faults are detected as in Operation.
- `UC_STACK_CHECK_EN` undefined:
  - No counter; `depth` is tied to 0.
  - JAL and RET always decode normally.
  - Only illegal opcodes raise a fault; `fault_code` is never 10 or 11.

## Structure
- Shared package `uc_pkg` holds:
  - opcode localparams (`OP_LI`, `OP_J`, `OP_JZ`, `OP_JNZ`, `OP_JAL`, `OP_RET`);
  - ALU op constants;
  - fault-code constants;
  - the two-value state typedef.
- Sub-module `uc_decode` is purely combinational. It maps opcode and `z` to raw control outputs plus `is_jal`, `is_ret` and `illegal` strobes.
- `uc` wraps `uc_decode` with the state register, the depth counter and the NOP gating.

## Test plan
- Reset for 1 cycle, then apply `opcode`=001000 (ADD) → `we3`=1, `wez`=1, `s_inc`=1, `s_inm`=0, `op`=010. Then apply `opcode`=100000 (LI) → `we3`=1, `wez`=0, `s_inm`=1, `op`=000.
- Apply JNZ with `z`=0 → `s_inc`=0, `s_inm`=1. Apply JNZ with `z`=1 → `s_inc`=1. Apply JZ with the opposite `z` values → mirrored results.
- With `STACK_DEPTH`=2: JAL, JAL → `depth`=2. A third JAL → NOP outputs, then after the edge `fault`=1, `fault_code`=11, `depth`=2.
- RET immediately after reset → `s_ret`=0, `s_inc`=1; next edge `fault_code`=10. A following ADD → `we3`=0, `wez`=0.
- Apply `opcode`=111111 → NOP outputs, then `fault_code`=01. A later RET at `depth`=0 leaves `fault_code`=01.
- In FAULT with `depth`=1, assert `reset` for 1 edge → `fault`=0, `depth`=0. The next ADD decodes normally.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the microc control unit: opcodes, ALU ops, fault codes,
// state encoding and the bundled control-output struct.
package uc_pkg;

    localparam logic [5:0] OP_LI  = 6'b100000;
    localparam logic [5:0] OP_J   = 6'b110000;
    localparam logic [5:0] OP_JZ  = 6'b110001;
    localparam logic [5:0] OP_JNZ = 6'b110010;
    localparam logic [5:0] OP_JAL = 6'b110011;
    localparam logic [5:0] OP_RET = 6'b110100;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_ILLEGAL   = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;
    localparam logic [1:0] FC_OVERFLOW  = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic       s_ret;
        logic       s_rre;
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctrl_t;

endpackage

// File: rtl/uc_decode.sv
// Purely combinational opcode decode: raw control word plus jal/ret/illegal strobes.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       is_jal,
    output logic       is_ret,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        is_jal  = 1'b0;
        is_ret  = 1'b0;
        illegal = 1'b0;
        if (!opcode[5]) begin
            ctrl.we3   = 1'b1;
            ctrl.wez   = 1'b1;
            ctrl.s_inc = 1'b1;
            ctrl.op    = opcode[4:2];
        end else begin
            case (opcode)
                OP_LI: begin
                    ctrl.we3   = 1'b1;
                    ctrl.s_inc = 1'b1;
                    ctrl.s_inm = 1'b1;
                    ctrl.op    = ALU_PASS;
                end
                OP_J: ctrl.s_inm = 1'b1;
                OP_JZ: begin
                    ctrl.s_inm = z;
                    ctrl.s_inc = ~z;
                end
                OP_JNZ: begin
                    ctrl.s_inm = ~z;
                    ctrl.s_inc = z;
                end
                OP_JAL: begin
                    ctrl.s_inm = 1'b1;
                    ctrl.s_rre = 1'b1;
                    is_jal     = 1'b1;
                end
                OP_RET: begin
                    ctrl.s_ret = 1'b1;
                    is_ret     = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc.sv
// microc control unit: decode plus a RUN/FAULT supervisor with sticky fault code.
// Define UC_STACK_CHECK_EN to enable the call-depth counter and stack under/overflow faults.
module uc
    import uc_pkg::*;
#(
    parameter  int STACK_DEPTH = 8,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               z,
    output logic               s_inc,
    output logic               s_inm,
    output logic               s_ret,
    output logic               s_rre,
    output logic               we3,
    output logic               wez,
    output logic [2:0]         op,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [DEPTH_W-1:0] depth
);

    ctrl_t        raw;
    ctrl_t        ctrl;
    logic         is_jal;
    logic         is_ret;
    logic         illegal;
    logic         fault_hit;
    logic [1:0]   fcode_d;
    state_t       state_q;
    logic [1:0]   fcode_q;

    uc_decode u_decode (
        .opcode  (opcode),
        .z       (z),
        .ctrl    (raw),
        .is_jal  (is_jal),
        .is_ret  (is_ret),
        .illegal (illegal)
    );

`ifdef UC_STACK_CHECK_EN
    logic [DEPTH_W-1:0] depth_q;
    logic               underflow;
    logic               overflow;

    assign underflow = is_ret && (depth_q == '0);
    assign overflow  = is_jal && (depth_q == DEPTH_W'(STACK_DEPTH));
    assign fault_hit = illegal | underflow | overflow;
    assign fcode_d   = illegal   ? FC_ILLEGAL   :
                       underflow ? FC_UNDERFLOW : FC_OVERFLOW;
    assign depth     = depth_q;

    // Depth only moves for a legal JAL/RET retired in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else if (state_q == ST_RUN && !fault_hit) begin
            if (is_jal)
                depth_q <= depth_q + 1'b1;
            else if (is_ret)
                depth_q <= depth_q - 1'b1;
        end
    end
`else
    logic unused_stack_strobes;

    assign unused_stack_strobes = is_jal ^ is_ret;
    assign fault_hit = illegal;
    assign fcode_d   = FC_ILLEGAL;
    assign depth     = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            fcode_q <= FC_NONE;
        end else if (state_q == ST_RUN && fault_hit) begin
            state_q <= ST_FAULT;
            fcode_q <= fcode_d;
        end
    end

    // The faulting instruction itself is already squashed to a NOP.
    always_comb begin
        ctrl = raw;
        if (reset) begin
            ctrl = '0;
        end else if (state_q == ST_FAULT || fault_hit) begin
            ctrl       = '0;
            ctrl.s_inc = 1'b1;
        end
    end

    assign s_ret      = ctrl.s_ret;
    assign s_rre      = ctrl.s_rre;
    assign s_inc      = ctrl.s_inc;
    assign s_inm      = ctrl.s_inm;
    assign we3        = ctrl.we3;
    assign wez        = ctrl.wez;
    assign op         = ctrl.op;
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fcode_q;

endmodule

// File: tb/tb_uc.sv
// Directed bench for the microc control unit with STACK_DEPTH=2.
module tb_uc;

  localparam int SD = 2;
  localparam int DW = $clog2(SD + 1);

`ifdef UC_STACK_CHECK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  // {s_ret,s_rre,s_inc,s_inm,we3,wez,op}
  localparam logic [8:0] C_ZERO = 9'b000000000;
  localparam logic [8:0] C_ADD  = 9'b001011010;
  localparam logic [8:0] C_SUB  = 9'b001011011;
  localparam logic [8:0] C_A0   = 9'b001011000;
  localparam logic [8:0] C_A7   = 9'b001011111;
  localparam logic [8:0] C_LI   = 9'b001110000;
  localparam logic [8:0] C_TAKE = 9'b000100000;
  localparam logic [8:0] C_NOP  = 9'b001000000;
  localparam logic [8:0] C_JAL  = 9'b010100000;
  localparam logic [8:0] C_RET  = 9'b100000000;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          z;
  logic          s_inc, s_inm, s_ret, s_rre, we3, wez;
  logic [2:0]    op;
  logic          fault;
  logic [1:0]    fault_code;
  logic [DW-1:0] depth;
  logic [8:0]    ctrl;

  int checks = 0;
  int errors = 0;

  assign ctrl = {s_ret, s_rre, s_inc, s_inm, we3, wez, op};

  always #5 clk = ~clk;

  uc #(.STACK_DEPTH(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .z          (z),
    .s_inc      (s_inc),
    .s_inm      (s_inm),
    .s_ret      (s_ret),
    .s_rre      (s_rre),
    .we3        (we3),
    .wez        (wez),
    .op         (op),
    .fault      (fault),
    .fault_code (fault_code),
    .depth      (depth)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [5:0] o, input logic zz);
    opcode = o;
    z      = zz;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: simulation did not finish");
    $finish;
  end

  initial begin
    reset  = 1'b1;
    opcode = 6'b001000;
    z      = 1'b0;
    #1;
    check("ctrl_in_reset", ctrl, C_ZERO);
    tick();
    check("rst_fault", fault, 1'b0);
    check("rst_depth", depth, DW'(0));
    check("rst_code", fault_code, 2'b00);
    reset = 1'b0;

    apply(6'b001000, 1'b0); check("add", ctrl, C_ADD);
    apply(6'b100000, 1'b0); check("li", ctrl, C_LI);
    apply(6'b001100, 1'b0); check("sub", ctrl, C_SUB);
    apply(6'b000000, 1'b0); check("alu0", ctrl, C_A0);
    apply(6'b011111, 1'b0); check("alu7", ctrl, C_A7);
    apply(6'b110010, 1'b0); check("jnz_z0", ctrl, C_TAKE);
    apply(6'b110010, 1'b1); check("jnz_z1", ctrl, C_NOP);
    apply(6'b110001, 1'b1); check("jz_z1", ctrl, C_TAKE);
    apply(6'b110001, 1'b0); check("jz_z0", ctrl, C_NOP);
    apply(6'b110000, 1'b0); check("j", ctrl, C_TAKE);
    tick();
    check("legal_no_fault", fault, 1'b0);

    // Call depth up to the limit and one beyond.
    apply(6'b110011, 1'b0); check("jal1", ctrl, C_JAL);
    tick(); check("depth1", depth, STK ? DW'(1) : DW'(0));
    apply(6'b110011, 1'b0); check("jal2", ctrl, C_JAL);
    tick(); check("depth2", depth, STK ? DW'(2) : DW'(0));
    apply(6'b110011, 1'b0); check("jal3", ctrl, STK ? C_NOP : C_JAL);
    tick();
    check("ovf_fault", fault, STK);
    check("ovf_code", fault_code, STK ? 2'b11 : 2'b00);
    check("ovf_depth", depth, STK ? DW'(2) : DW'(0));
    apply(6'b001000, 1'b0); check("add_after_ovf", ctrl, STK ? C_NOP : C_ADD);

    // Return with an empty stack.
    do_reset();
    apply(6'b110100, 1'b0); check("ret_empty", ctrl, STK ? C_NOP : C_RET);
    tick();
    check("unf_fault", fault, STK);
    check("unf_code", fault_code, STK ? 2'b10 : 2'b00);
    apply(6'b001000, 1'b0); check("add_after_unf", ctrl, STK ? C_NOP : C_ADD);

    // Illegal opcode, then a later fault must not overwrite the code.
    do_reset();
    apply(6'b111111, 1'b0); check("illegal", ctrl, C_NOP);
    tick();
    check("ill_fault", fault, 1'b1);
    check("ill_code", fault_code, 2'b01);
    apply(6'b110100, 1'b0); check("ret_in_fault", ctrl, C_NOP);
    tick(); check("code_sticky", fault_code, 2'b01);
    apply(6'b110011, 1'b0); check("jal_in_fault", ctrl, C_NOP);
    tick(); check("depth_frozen", depth, DW'(0));
    apply(6'b101010, 1'b0); tick();
    check("code_sticky2", fault_code, 2'b01);

    // Reset out of FAULT with a nonzero depth.
    do_reset();
    apply(6'b110011, 1'b0); tick();
    apply(6'b100001, 1'b0); check("illegal2", ctrl, C_NOP);
    tick();
    check("f_depth1", depth, STK ? DW'(1) : DW'(0));
    check("f_fault", fault, 1'b1);
    reset = 1'b1;
    apply(6'b001000, 1'b0); check("ctrl_reset_fault", ctrl, C_ZERO);
    tick();
    reset = 1'b0;
    #1;
    check("rr_fault", fault, 1'b0);
    check("rr_depth", depth, DW'(0));
    check("rr_code", fault_code, 2'b00);
    check("rr_add", ctrl, C_ADD);

    // RET at depth 1 is legal and empties the stack.
    apply(6'b110011, 1'b0); tick();
    apply(6'b110100, 1'b0); check("ret_d1", ctrl, C_RET);
    tick();
    check("ret_d1_depth", depth, DW'(0));
    check("ret_d1_fault", fault, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
